echo_scheduler: RTL and testbench
=================================

ECHO_SCHEDULER -- requirements
Module: echo_scheduler

Interface
REQ-001 SHALL have parameter FB_SHIFT, default 1, feedback gain as arithmetic right shift (gain 2^-FB_SHIFT).
REQ-002 SHALL have parameter ADDR_W, default 15, shared delay RAM address width.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  echo on (1) / bypass (0), sampled only when a sample is accepted.
REQ-006 SHALL have port sample_valid  input  1  one-cycle strobe marking new in_L/in_R.
REQ-007 SHALL have ports in_L, in_R  input  32  signed audio samples.
REQ-008 SHALL have ports out_L, out_R  output  32  signed mixed samples, registered.
REQ-009 SHALL have port out_valid  output  1  one-cycle strobe marking new out_L/out_R.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when sample_valid arrives while busy.
REQ-012 SHALL have ports mem_addr (output ADDR_W), mem_rd_en (output 1), mem_we (output 1), mem_wdata (output 32), mem_rdata (input 32): external single-port RAM, read data valid the cycle after mem_rd_en.

Function
REQ-013 SHALL time-multiplex 8 comb taps over the shared RAM: taps 0-3 use in_L, depths 3203/3571/4211/4877; taps 4-7 use in_R, depths 3301/3697/4337/4999.
REQ-014 SHALL place tap k at base address = sum of preceding depths (0, 3203, 6774, 10985, 15862, 19163, 22860, 27197); total 32196 words.
REQ-015 SHALL keep per-tap pointer ptr[k]; access address = base[k] + ptr[k].
REQ-016 SHALL implement states CLEAR, IDLE, READ, CAPTURE, WRITE, OUTPUT.
REQ-017 IDLE: sample_valid with enable=1 latches inputs, tap=0, goes READ; with enable=0 goes OUTPUT, no RAM access, pointers hold.
REQ-018 READ: mem_rd_en=1 at tap address -> CAPTURE.
REQ-019 CAPTURE: register delayed = mem_rdata; wet accumulator (34-bit signed) += delayed -> WRITE.
REQ-020 WRITE: mem_we=1, mem_wdata = saturate32(in + (delayed >>> FB_SHIFT)); ptr[k] increments, wraps to 0 after depth-1; tap 7 -> OUTPUT, else tap+1 -> READ.
REQ-021 OUTPUT: enabled frame: out = saturate32((in >>> 2) + (wet >>> 2)) per channel in 35-bit signed; bypass frame: out = in; out_valid=1 -> IDLE.
REQ-022 Enabled latency: out_valid exactly 25 cycles after the accepting edge; bypass latency: 1 cycle.
REQ-023 sample_valid while busy SHALL be dropped, pulse overrun next cycle, not disturb the frame.
REQ-024 mem_rd_en and mem_we SHALL never be high in the same cycle.
REQ-025 Saturation bounds: 0x7FFFFFFF / 0x80000000.

Reset
REQ-026 Reset SHALL set out_L=out_R=0, out_valid=0, overrun=0, mem_rd_en=mem_we=0, all ptr=0, wet=0.
REQ-027 Reset mid-frame SHALL abort the frame with no out_valid and no further RAM write.
REQ-028 State after reset SHALL be CLEAR if ECHO_MEM_CLEAR_EN defined, else IDLE (busy=0).

Configuration
REQ-029 With ECHO_MEM_CLEAR_EN defined: CLEAR writes 0 to addresses 0..32195, one per cycle (busy=1, samples dropped with overrun), then IDLE.
REQ-030 Without ECHO_MEM_CLEAR_EN: no CLEAR state; RAM contents are the integrator's responsibility.

Verification
REQ-031 Reset with ECHO_MEM_CLEAR_EN -> busy high 32196 cycles, mem_we each cycle, addr 0..32195, wdata 0, then busy low.
REQ-032 enable=0, in_L=0x12345678, in_R=0xFFFF0000 -> next cycle out_valid, out_L=0x12345678, out_R=0xFFFF0000, no RAM access.
REQ-033 Zeroed RAM, enable=1, in_L=0x40000000, in_R=0 -> out_valid 25 cycles later, out_L=0x10000000, out_R=0; 0x40000000 written to 0/3203/6774/10985; after 3203 further zero samples, frame reads 0x40000000 at address 0, out_L=0x10000000, writes 0x20000000.
REQ-034 RAM preloaded 0x7FFFFFFF at all tap addresses, in_L=0x7FFFFFFF -> out_L=0x7FFFFFFF, tap 0-3 writes 0x7FFFFFFF.
REQ-035 sample_valid 10 cycles into a frame -> one overrun pulse, original frame out_valid still at cycle 25, second sample lost.
REQ-036 reset asserted 12 cycles into a frame -> no out_valid, all ptr=0, next accepted frame addresses 0, 3203, ..., 27197.

Source files
------------

// File: rtl/echo_scheduler.sv
// Stereo multi-tap comb echo: eight delay taps share one external single-port RAM, one tap per 3-cycle slot.
// Optional build macro ECHO_MEM_CLEAR_EN adds a post-reset CLEAR sweep that zeroes the delay RAM.
module echo_scheduler #(
    parameter int FB_SHIFT = 1,
    parameter int ADDR_W   = 15
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [31:0]       in_L,
    input  logic [31:0]       in_R,
    output logic [31:0]       out_L,
    output logic [31:0]       out_R,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int MEM_WORDS = 32196;
    localparam int TAP_BASE  [8] = '{0, 3203, 6774, 10985, 15862, 19163, 22860, 27197};
    localparam int TAP_DEPTH [8] = '{3203, 3571, 4211, 4877, 3301, 3697, 4337, 4999};

`ifdef ECHO_MEM_CLEAR_EN
    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_OUTPUT} state_t;
    localparam state_t RESET_STATE = S_CLEAR;
    logic [ADDR_W-1:0] clr_reg;
`else
    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_OUTPUT} state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t state_reg, state_next;

    logic [2:0]         tap_reg;
    logic [31:0]        in_l_reg, in_r_reg;
    logic               frame_en_reg;
    logic [31:0]        delayed_reg;
    logic signed [33:0] wet_l_reg, wet_r_reg;
    logic [31:0]        out_l_reg, out_r_reg;
    logic               out_valid_reg, overrun_reg;

    logic [ADDR_W-1:0]  tap_addr [8];

    function automatic logic [31:0] sat32(input logic signed [34:0] v);
        if (v > 35'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (v < -35'sh8000_0000) return 32'h8000_0000;
        return v[31:0];
    endfunction

    // Per-tap circular pointers; each advances only on its own WRITE slot.
    for (genvar gi = 0; gi < 8; gi++) begin : g_tap
        logic [ADDR_W-1:0] ptr_reg;
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                ptr_reg <= '0;
            end else if (state_reg == S_WRITE && tap_reg == 3'(gi)) begin
                if (ptr_reg == ADDR_W'(TAP_DEPTH[gi] - 1))
                    ptr_reg <= '0;
                else
                    ptr_reg <= ptr_reg + 1'b1;
            end
        end
        assign tap_addr[gi] = ADDR_W'(TAP_BASE[gi]) + ptr_reg;
    end

    logic [31:0]        tap_in;
    logic signed [34:0] tap_in_x, delayed_x, fb_x, wsum;
    logic signed [34:0] in_l_x, in_r_x, wet_l_x, wet_r_x, mix_l, mix_r;

    assign tap_in    = tap_reg[2] ? in_r_reg : in_l_reg;
    assign tap_in_x  = {{3{tap_in[31]}}, tap_in};
    assign delayed_x = {{3{delayed_reg[31]}}, delayed_reg};
    assign fb_x      = delayed_x >>> FB_SHIFT;
    assign wsum      = tap_in_x + fb_x;

    assign in_l_x  = {{3{in_l_reg[31]}}, in_l_reg};
    assign in_r_x  = {{3{in_r_reg[31]}}, in_r_reg};
    assign wet_l_x = {wet_l_reg[33], wet_l_reg};
    assign wet_r_x = {wet_r_reg[33], wet_r_reg};
    assign mix_l   = (in_l_x >>> 2) + (wet_l_x >>> 2);
    assign mix_r   = (in_r_x >>> 2) + (wet_r_x >>> 2);

    always_ff @(posedge CLOCK_50) begin
        if (reset) state_reg <= RESET_STATE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
`ifdef ECHO_MEM_CLEAR_EN
            S_CLEAR:   if (clr_reg == ADDR_W'(MEM_WORDS - 1)) state_next = S_IDLE;
`endif
            S_IDLE:    if (sample_valid) state_next = enable ? S_READ : S_OUTPUT;
            S_READ:    state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_WRITE;
            S_WRITE:   state_next = (tap_reg == 3'd7) ? S_OUTPUT : S_READ;
            S_OUTPUT:  state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // RAM strobes are masked by reset so an aborted frame cannot land a write on the reset cycle.
    always_comb begin
        busy      = (state_reg != S_IDLE);
        mem_addr  = tap_addr[tap_reg];
        mem_rd_en = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = sat32(wsum);
        case (state_reg)
`ifdef ECHO_MEM_CLEAR_EN
            S_CLEAR: begin
                mem_addr  = clr_reg;
                mem_we    = ~reset;
                mem_wdata = '0;
            end
`endif
            S_READ:  mem_rd_en = ~reset;
            S_WRITE: mem_we    = ~reset;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tap_reg       <= '0;
            in_l_reg      <= '0;
            in_r_reg      <= '0;
            frame_en_reg  <= 1'b0;
            delayed_reg   <= '0;
            wet_l_reg     <= '0;
            wet_r_reg     <= '0;
            out_l_reg     <= '0;
            out_r_reg     <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
`ifdef ECHO_MEM_CLEAR_EN
            clr_reg       <= '0;
`endif
        end else begin
            overrun_reg   <= sample_valid && (state_reg != S_IDLE);
            out_valid_reg <= 1'b0;
            case (state_reg)
`ifdef ECHO_MEM_CLEAR_EN
                S_CLEAR: clr_reg <= clr_reg + 1'b1;
`endif
                S_IDLE: begin
                    if (sample_valid) begin
                        in_l_reg     <= in_L;
                        in_r_reg     <= in_R;
                        frame_en_reg <= enable;
                        tap_reg      <= '0;
                        wet_l_reg    <= '0;
                        wet_r_reg    <= '0;
                    end
                end
                S_CAPTURE: begin
                    delayed_reg <= mem_rdata;
                    if (tap_reg[2])
                        wet_r_reg <= wet_r_reg + {{2{mem_rdata[31]}}, mem_rdata};
                    else
                        wet_l_reg <= wet_l_reg + {{2{mem_rdata[31]}}, mem_rdata};
                end
                S_WRITE: tap_reg <= tap_reg + 1'b1;
                S_OUTPUT: begin
                    out_valid_reg <= 1'b1;
                    out_l_reg     <= frame_en_reg ? sat32(mix_l) : in_l_reg;
                    out_r_reg     <= frame_en_reg ? sat32(mix_r) : in_r_reg;
                end
                default: ;
            endcase
        end
    end

    assign out_L     = out_l_reg;
    assign out_R     = out_r_reg;
    assign out_valid = out_valid_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_echo_scheduler.sv
// Scoreboard bench for echo_scheduler: a behavioural RAM plus an independent tap model predicting reads, writes and mixes.
module tb_echo_scheduler;

    localparam int FB    = 1;
    localparam int AW    = 15;
    localparam int WORDS = 32196;
    localparam int BASE  [8] = '{0, 3203, 6774, 10985, 15862, 19163, 22860, 27197};
    localparam int DEPTH [8] = '{3203, 3571, 4211, 4877, 3301, 3697, 4337, 4999};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1, enable = 1'b0, sample_valid = 1'b0;
    logic [31:0]   in_L = '0, in_R = '0;
    logic [31:0]   out_L, out_R, mem_wdata;
    logic          out_valid, busy, overrun, mem_rd_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;

    echo_scheduler #(.FB_SHIFT(FB), .ADDR_W(AW)) dut (
        .CLOCK_50(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .in_L(in_L), .in_R(in_R), .out_L(out_L), .out_R(out_R), .out_valid(out_valid),
        .busy(busy), .overrun(overrun), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port RAM with a backdoor port for zeroing and preloading.
    logic [31:0] ram [0:32767];
    logic        tb_zero = 1'b0, tb_we = 1'b0;
    int          tb_addr = 0;
    logic [31:0] tb_wdata = '0;
    always @(posedge clk) begin
        if (tb_zero) for (int i = 0; i < 32768; i++) ram[i] <= '0;
        else if (tb_we) ram[tb_addr] <= tb_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [31:0] l; logic [31:0] r; int cyc; } out_t;
    typedef struct packed { int addr; logic [31:0] data; } wr_t;
    out_t oq[$];
    wr_t  wq[$];
    int   rq[$];

    logic [31:0] model_mem [0:32767];
    int   mptr [8];
    int   n_tests = 0, n_fail = 0;
    logic started = 1'b0, clearing = 1'b0;
    int   clr_idx = 0;

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [31:0] sat(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    // Scoreboard monitor: pops expected reads, writes and outputs as the DUT produces them.
    always @(negedge clk) begin
        if (started && !reset) begin
            if (mem_rd_en && mem_we) begin
                n_tests++; n_fail++;
                $display("FAIL rd_we_overlap addr=%0d got both strobes high, required at most one", mem_addr);
            end
            if (mem_rd_en) begin
                n_tests++;
                if (rq.size() == 0) begin
                    n_fail++; $display("FAIL unexpected_read addr=%0d required no read", mem_addr);
                end else begin
                    int ea;
                    ea = rq.pop_front();
                    if (32'(mem_addr) !== ea) begin
                        n_fail++; $display("FAIL read_addr got %0d required %0d", mem_addr, ea);
                    end
                end
            end
            if (mem_we) begin
                n_tests++;
                if (clearing) begin
                    if (32'(mem_addr) !== clr_idx || mem_wdata !== 32'h0) begin
                        n_fail++;
                        $display("FAIL clear_write got addr=%0d data=%h required addr=%0d data=0", mem_addr, mem_wdata, clr_idx);
                    end
                    clr_idx++;
                end else if (wq.size() == 0) begin
                    n_fail++; $display("FAIL unexpected_write addr=%0d data=%h required no write", mem_addr, mem_wdata);
                end else begin
                    wr_t ew;
                    ew = wq.pop_front();
                    if (32'(mem_addr) !== ew.addr || mem_wdata !== ew.data) begin
                        n_fail++;
                        $display("FAIL write got addr=%0d data=%h required addr=%0d data=%h", mem_addr, mem_wdata, ew.addr, ew.data);
                    end
                end
            end
            if (out_valid) begin
                n_tests++;
                if (oq.size() == 0) begin
                    n_fail++; $display("FAIL unexpected_out_valid L=%h R=%h required no output", out_L, out_R);
                end else begin
                    out_t eo;
                    eo = oq.pop_front();
                    if (out_L !== eo.l || out_R !== eo.r || cyc !== eo.cyc) begin
                        n_fail++;
                        $display("FAIL output got L=%h R=%h cyc=%0d required L=%h R=%h cyc=%0d", out_L, out_R, cyc, eo.l, eo.r, eo.cyc);
                    end else begin
                        $display("[TB] out L=%h R=%h at cycle %0d", out_L, out_R, cyc);
                    end
                end
            end
        end
    end

    task automatic send(input logic en, input logic [31:0] l, input logic [31:0] r);
        longint wl, wr, s;
        int a;
        logic [31:0] d, w;
        @(posedge clk); #1;
        enable = en; in_L = l; in_R = r; sample_valid = 1'b1;
        if (en) begin
            wl = 0; wr = 0;
            for (int k = 0; k < 8; k++) begin
                a = BASE[k] + mptr[k];
                d = model_mem[a];
                if (k < 4) begin wl += sx(d); s = sx(l) + (sx(d) >>> FB); end
                else       begin wr += sx(d); s = sx(r) + (sx(d) >>> FB); end
                w = sat(s);
                rq.push_back(a);
                wq.push_back('{a, w});
                model_mem[a] = w;
                mptr[k] = (mptr[k] == DEPTH[k] - 1) ? 0 : mptr[k] + 1;
            end
            oq.push_back('{sat((sx(l) >>> 2) + (wl >>> 2)), sat((sx(r) >>> 2) + (wr >>> 2)), cyc + 26});
        end else begin
            oq.push_back('{l, r, cyc + 2});
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while ((oq.size() != 0 || wq.size() != 0 || rq.size() != 0) && i < 60) begin
            @(posedge clk); i++;
        end
        #1;
        n_tests++;
        if (oq.size() != 0 || wq.size() != 0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout pending out=%0d wr=%0d rd=%0d required 0", name, oq.size(), wq.size(), rq.size());
            oq.delete(); wq.delete(); rq.delete();
        end
    endtask

    task automatic backdoor(input int a, input logic [31:0] v);
        @(posedge clk); #1;
        tb_we = 1'b1; tb_addr = a; tb_wdata = v;
        @(posedge clk); #1;
        tb_we = 1'b0;
        model_mem[a] = v;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        oq.delete(); wq.delete(); rq.delete();
        sample_valid = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) mptr[k] = 0;
`ifdef ECHO_MEM_CLEAR_EN
        clearing = 1'b1; clr_idx = 0;
        reset = 1'b0;
        for (int i = 0; i < 33000 && (busy || i == 0); i++) @(posedge clk);
        #1;
        clearing = 1'b0;
        n_tests++;
        if (clr_idx !== WORDS || busy !== 1'b0) begin
            n_fail++; $display("FAIL clear_sweep got writes=%0d busy=%b required writes=%0d busy=0", clr_idx, busy, WORDS);
        end
        for (int i = 0; i < 32768; i++) model_mem[i] = '0;
`else
        reset = 1'b0;
        for (int i = 0; i < 32768; i++) model_mem[i] = ram[i];
`endif
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (out_L !== 32'h0 || out_R !== 32'h0 || out_valid !== 1'b0 || overrun !== 1'b0 ||
            mem_rd_en !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got L=%h R=%h ov=%b orun=%b rd=%b we=%b required all 0",
                     out_L, out_R, out_valid, overrun, mem_rd_en, mem_we);
        end
        apply_reset();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got %b required 0", busy);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_bypass();
        send(1'b0, 32'h1234_5678, 32'hFFFF_0000);
        wait_drain("bypass");
        send(1'b0, 32'h8000_0000, 32'h7FFF_FFFF);
        wait_drain("bypass2");
    endtask

    task automatic test_echo_basic();
        send(1'b1, 32'h4000_0000, 32'h0);
        wait_drain("echo_first");
        n_tests++;
        if (ram[0] !== 32'h4000_0000 || ram[3203] !== 32'h4000_0000 || ram[6774] !== 32'h4000_0000 ||
            ram[10985] !== 32'h4000_0000 || ram[19163] !== 32'h0) begin
            n_fail++;
            $display("FAIL echo_ram got %h %h %h %h %h required 40000000 x4 then 0",
                     ram[0], ram[3203], ram[6774], ram[10985], ram[19163]);
        end
        send(1'b1, 32'h0, 32'hFFFF_FFF0);
        wait_drain("echo_second");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 8; k++) backdoor(BASE[k] + mptr[k], 32'h7FFF_FFFF);
        send(1'b1, 32'h7FFF_FFFF, 32'h0);
        wait_drain("sat_pos");
        for (int k = 0; k < 8; k++) backdoor(BASE[k] + mptr[k], 32'h8000_0000);
        send(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_drain("sat_neg");
    endtask

    task automatic test_overrun();
        send(1'b1, 32'h0100_0000, 32'h0200_0000);
        repeat (8) @(posedge clk);
        #1;
        in_L = 32'hDEAD_BEEF; in_R = 32'h1111_1111; enable = 1'b1; sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        n_tests++;
        if (overrun !== 1'b1) begin
            n_fail++; $display("FAIL overrun_pulse got %b required 1", overrun);
        end
        @(posedge clk); #1;
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++; $display("FAIL overrun_single got %b required 0", overrun);
        end
        wait_drain("overrun_frame");
        repeat (30) @(posedge clk);
    endtask

    task automatic test_reset_mid_frame();
        send(1'b1, 32'h0333_0000, 32'hF000_0000);
        repeat (10) @(posedge clk);
        apply_reset();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state got ov=%b busy=%b required 0 0", out_valid, busy);
        end
        repeat (30) @(posedge clk);
        send(1'b1, 32'h0000_1000, 32'h0000_2000);
        wait_drain("after_midreset");
    endtask

    task automatic test_back_to_back();
        logic [31:0] l, r;
        logic en;
        for (int n = 0; n < 12; n++) begin
            l = $urandom(); r = $urandom(); en = (n % 3) != 0;
            send(en, l, r);
            if (!en) send(1'b0, ~l, ~r);
            wait_drain("b2b");
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) mptr[k] = 0;
        for (int i = 0; i < 32768; i++) model_mem[i] = '0;
        tb_zero = 1'b1;
        @(posedge clk); #1;
        tb_zero = 1'b0;
        @(posedge clk);
        started = 1'b1;
        test_reset();
        test_bypass();
        test_echo_basic();
        test_saturation();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        n_tests++;
        if (oq.size() != 0 || wq.size() != 0 || rq.size() != 0) begin
            n_fail++; $display("FAIL final_queues pending out=%0d wr=%0d rd=%0d required 0", oq.size(), wq.size(), rq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
